// File: rtl/whack_game_ctrl.sv
// Whack-an-engineer game controller: conditions the buttons, picks the active hard hat,
// scores hits and misses, and sequences idle -> play -> game over -> restart.
module whack_game_ctrl #(
  parameter int          CLOCK_FREQ   = 50000000,
  parameter int          MOLE_PERIOD  = 50000000,
  parameter int          HIT_HOLD     = 12500000,
  parameter int          GAME_SECONDS = 30,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic       clk,
  input  logic       iResetn,
  input  logic       iStart,
  input  logic [4:0] iKeys,
  output logic [2:0] gameState,
  output logic [4:0] hhSelect,
  output logic       moleHit,
  output logic [7:0] oScore,
  output logic [7:0] oMisses,
  output logic [6:0] oTimeLeft
);

  localparam int TW = (CLOCK_FREQ > 1) ? $clog2(CLOCK_FREQ) : 1;
  localparam int PW = (MOLE_PERIOD > 1) ? $clog2(MOLE_PERIOD) : 1;
  localparam int HW = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;

  localparam logic [TW-1:0] TICK_MAX   = TW'(CLOCK_FREQ - 1);
  localparam logic [PW-1:0] PERIOD_MAX = PW'(MOLE_PERIOD - 1);
  localparam logic [HW-1:0] HOLD_MAX   = HW'(HIT_HOLD - 1);
  localparam logic [6:0]    TIME_LOAD  = 7'(GAME_SECONDS);

  typedef enum logic [2:0] {
    IDLE      = 3'd1,
    PLAY      = 3'd2,
    RESTART   = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  state_t        state;
  logic [15:0]   lfsr;
  logic [TW-1:0] tick_cnt;
  logic [PW-1:0] period_cnt;
  logic [HW-1:0] hold_cnt;
  logic          mole_done;

  // Bit 5 is the start button, bits 4:0 the hit keys. The press pulse is registered
  // so a key edge reaches moleHit three clocks after it is first sampled.
  logic [5:0] sync1, sync2, sync3, press;

  always_ff @(posedge clk) begin
    if (iResetn) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
      press <= '0;
    end else begin
      sync1 <= {iStart, iKeys};
      sync2 <= sync1;
      sync3 <= sync2;
      press <= sync2 & ~sync3;
    end
  end

  logic       start_press;
  logic [4:0] key_press;
  assign start_press = press[5];
  assign key_press   = press[4:0];

  logic       lfsr_fb;
  logic [2:0] raw_idx, base_idx, pick_idx;
  logic [4:0] pick_sel;

  // Fold the 3-bit LFSR slice into 0..4, then step past the current hat so it always moves.
  always_comb begin
    lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
    raw_idx  = lfsr[2:0];
    base_idx = (raw_idx >= 3'd5) ? (raw_idx - 3'd5) : raw_idx;
    pick_idx = base_idx;
    if ((5'b00001 << base_idx) == hhSelect) begin
      pick_idx = (base_idx == 3'd4) ? 3'd0 : (base_idx + 3'd1);
    end
    pick_sel = 5'b00001 << pick_idx;
  end

  logic is_hit, tick_wrap, expire;

  always_comb begin
    is_hit    = (key_press != 5'd0) && (key_press == hhSelect) && !moleHit && !mole_done;
    tick_wrap = (tick_cnt == TICK_MAX);
    expire    = (oTimeLeft == 7'd0) || (tick_wrap && (oTimeLeft == 7'd1));
  end

  assign gameState = state;

  always_ff @(posedge clk) begin
    if (iResetn) begin
      state      <= IDLE;
      hhSelect   <= '0;
      moleHit    <= 1'b0;
      oScore     <= '0;
      oMisses    <= '0;
      oTimeLeft  <= TIME_LOAD;
      lfsr       <= LFSR_SEED;
      tick_cnt   <= '0;
      period_cnt <= '0;
      hold_cnt   <= '0;
      mole_done  <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
      case (state)
        IDLE: begin
          if (start_press) begin
            state      <= PLAY;
            hhSelect   <= pick_sel;
            moleHit    <= 1'b0;
            oTimeLeft  <= TIME_LOAD;
            tick_cnt   <= '0;
            period_cnt <= '0;
            hold_cnt   <= '0;
            mole_done  <= 1'b0;
          end
        end

        PLAY: begin
          if (expire) begin
            // Expiry outranks any hit landing on the same edge.
            state     <= GAME_OVER;
            hhSelect  <= '0;
            moleHit   <= 1'b0;
            oTimeLeft <= 7'd0;
            tick_cnt  <= '0;
          end else begin
            if (tick_wrap) begin
              tick_cnt  <= '0;
              oTimeLeft <= oTimeLeft - 7'd1;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end

            if (is_hit) begin
              moleHit   <= 1'b1;
              hold_cnt  <= '0;
              mole_done <= 1'b1;
              if (oScore != 8'hFF) oScore <= oScore + 8'd1;
            end else begin
              if ((key_press != 5'd0) && (oMisses != 8'hFF)) oMisses <= oMisses + 8'd1;
              if (moleHit) begin
                // Period counter stays frozen while the hit is shown; it restarts on the fall.
                if (hold_cnt == HOLD_MAX) begin
                  moleHit    <= 1'b0;
                  period_cnt <= '0;
                end else begin
                  hold_cnt <= hold_cnt + 1'b1;
                end
              end else if (period_cnt == PERIOD_MAX) begin
                period_cnt <= '0;
                hhSelect   <= pick_sel;
                mole_done  <= 1'b0;
              end else begin
                period_cnt <= period_cnt + 1'b1;
              end
            end
          end
        end

        GAME_OVER: begin
          if (start_press) state <= RESTART;
        end

        RESTART: begin
          state      <= PLAY;
          hhSelect   <= pick_sel;
          moleHit    <= 1'b0;
          oScore     <= '0;
          oMisses    <= '0;
          oTimeLeft  <= TIME_LOAD;
          tick_cnt   <= '0;
          period_cnt <= '0;
          hold_cnt   <= '0;
          mole_done  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_whack_game_ctrl.sv
// Bench for whack_game_ctrl with short timing parameters; t counts clocks since the
// edge that entered the current game.
module tb_whack_game_ctrl;

  localparam int W     = 16;
  localparam int CLK_F = 100;
  localparam int MP    = 40;
  localparam int HH    = 10;
  localparam int GS    = 3;
  localparam int GAME  = GS * CLK_F;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] keys;
  logic [2:0] game_state;
  logic [4:0] hh_select;
  logic       mole_hit;
  logic [7:0] score, misses;
  logic [6:0] time_left;

  int checks = 0;
  int errors = 0;
  int t = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  whack_game_ctrl #(
    .CLOCK_FREQ(CLK_F), .MOLE_PERIOD(MP), .HIT_HOLD(HH),
    .GAME_SECONDS(GS), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .iResetn(rst), .iStart(start), .iKeys(keys),
    .gameState(game_state), .hhSelect(hh_select), .moleHit(mole_hit),
    .oScore(score), .oMisses(misses), .oTimeLeft(time_left)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    t += n;
  endtask

  task automatic step_to(input int target);
    while (t < target) step(1);
  endtask

  // Driver: press start from GAME_OVER and wait for the new game to begin.
  task automatic do_restart();
    int n = 0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    while (game_state !== 3'd2 && n < 10) begin
      step(1);
      n++;
    end
    checks++;
    if (game_state !== 3'd2) begin
      errors++;
      $display("FAIL restart_timeout: gameState=%0d required 2", game_state);
    end
    t = 0;
  endtask

  task automatic test_reset();
    int bad = 0;
    rst = 1'b1; start = 1'b0; keys = '0;
    step(2);
    rst = 1'b0;
    checks++;
    if (game_state !== 3'd1 || hh_select !== 5'd0 || mole_hit !== 1'b0 ||
        score !== 8'd0 || misses !== 8'd0 || time_left !== 7'd3) begin
      errors++;
      $display("FAIL reset_values: state=%0d sel=%b hit=%b score=%0d miss=%0d time=%0d required 1 00000 0 0 0 3",
               game_state, hh_select, mole_hit, score, misses, time_left);
    end
    for (int i = 0; i < 50; i++) begin
      step(1);
      if (hh_select !== 5'd0 || game_state !== 3'd1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL idle_hold: %0d idle cycles with sel!=0 or state!=1, required 0", bad);
    end
  endtask

  task automatic test_start();
    int edges = 1;
    start = 1'b1;
    step(1);
    start = 1'b0;
    while (game_state !== 3'd2 && edges < 8) begin
      step(1);
      edges++;
    end
    checks++;
    if (game_state !== 3'd2 || edges > 4) begin
      errors++;
      $display("FAIL start_latency: state=%0d after %0d edges, required 2 within 4", game_state, edges);
    end
    t = 0;
    checks++;
    if (!$onehot(hh_select)) begin
      errors++;
      $display("FAIL start_pick: sel=%b required one-hot", hh_select);
    end
  endtask

  task automatic test_mole_changes();
    int picks = 0;
    logic [4:0] prev;
    while (picks < 20) begin
      if (t + MP < GAME) begin
        prev = hh_select;
        step(MP - 1);
        checks++;
        if (hh_select !== prev) begin
          errors++;
          $display("FAIL mole_hold: t=%0d sel=%b required %b", t, hh_select, prev);
        end
        step(1);
        checks++;
        if (!$onehot(hh_select) || hh_select === prev) begin
          errors++;
          $display("FAIL mole_change: t=%0d sel=%b required one-hot different from %b", t, hh_select, prev);
        end
        picks++;
      end else begin
        step_to(GAME);
        checks++;
        if (game_state !== 3'd4) begin
          errors++;
          $display("FAIL period_game_over: state=%0d required 4", game_state);
        end
        do_restart();
      end
    end
    step_to(GAME);
    do_restart();
  endtask

  task automatic test_hit();
    logic [4:0] sel;
    logic [W-1:0] e;
    logic exp_hit;
    step_to(5);
    sel = hh_select;
    keys = sel;
    exp_q.push_back({8'd1, 8'd0});
    while (t < 31) begin
      step(1);
      if (t == 7) keys = '0;
      exp_hit = (t >= 9) && (t <= 8 + HH);
      checks++;
      if (mole_hit !== exp_hit || hh_select !== sel) begin
        errors++;
        $display("FAIL hit_window: t=%0d hit=%b sel=%b required %b %b", t, mole_hit, hh_select, exp_hit, sel);
      end
      if (t == 9) begin
        e = exp_q.pop_front();
        checks++;
        if ({score, misses} !== e) begin
          errors++;
          $display("FAIL hit_score: score=%0d miss=%0d required %0d %0d", score, misses, e[15:8], e[7:0]);
        end
      end
    end
  endtask

  task automatic test_misses();
    logic [4:0] cur, wrong;
    logic [W-1:0] e;
    logic [4:0] pat [3];
    step_to(32);
    cur = hh_select;
    wrong = {cur[3:0], cur[4]};
    pat[0] = wrong; pat[1] = cur | wrong; pat[2] = cur;
    for (int i = 0; i < 3; i++) begin
      step_to(32 + 7 * i);
      keys = pat[i];
      exp_q.push_back({8'd1, 8'(i + 1)});
      step(2);
      keys = '0;
      step_to(36 + 7 * i);
      e = exp_q.pop_front();
      checks++;
      if ({score, misses} !== e || mole_hit !== 1'b0) begin
        errors++;
        $display("FAIL miss_%0d: score=%0d miss=%0d hit=%b required %0d %0d 0",
                 i, score, misses, mole_hit, e[15:8], e[7:0]);
      end
    end
  endtask

  task automatic test_game_over();
    logic [W-1:0] e;
    exp_q.push_back({8'd1, 8'd3});
    step_to(GAME - 1);
    checks++;
    if (game_state !== 3'd2 || time_left !== 7'd1) begin
      errors++;
      $display("FAIL pre_expiry: state=%0d time=%0d required 2 1", game_state, time_left);
    end
    step(1);
    e = exp_q.pop_front();
    checks++;
    if (game_state !== 3'd4 || hh_select !== 5'd0 || mole_hit !== 1'b0 ||
        time_left !== 7'd0 || {score, misses} !== e) begin
      errors++;
      $display("FAIL game_over: state=%0d sel=%b hit=%b time=%0d score=%0d miss=%0d required 4 00000 0 0 %0d %0d",
               game_state, hh_select, mole_hit, time_left, score, misses, e[15:8], e[7:0]);
    end
    step(20);
    checks++;
    if (game_state !== 3'd4 || score !== 8'd1 || misses !== 8'd3) begin
      errors++;
      $display("FAIL game_over_hold: state=%0d score=%0d miss=%0d required 4 1 3", game_state, score, misses);
    end
  endtask

  task automatic test_restart();
    int n3 = 0;
    int n = 0;
    start = 1'b1;
    step(1);
    start = 1'b0;
    while (game_state !== 3'd2 && n < 10) begin
      step(1);
      n++;
      if (game_state === 3'd3) n3++;
    end
    t = 0;
    checks++;
    if (game_state !== 3'd2 || n3 != 1) begin
      errors++;
      $display("FAIL restart_pulse: state=%0d restart_cycles=%0d required 2 1", game_state, n3);
    end
    checks++;
    if (score !== 8'd0 || misses !== 8'd0 || time_left !== 7'd3 || !$onehot(hh_select)) begin
      errors++;
      $display("FAIL restart_values: score=%0d miss=%0d time=%0d sel=%b required 0 0 3 one-hot",
               score, misses, time_left, hh_select);
    end
  endtask

  task automatic test_expiry_hit();
    logic [W-1:0] e;
    step_to(GAME - 4);
    keys = hh_select;
    exp_q.push_back({8'd0, 8'd0});
    step(2);
    keys = '0;
    step_to(GAME - 1);
    checks++;
    if (game_state !== 3'd2 || mole_hit !== 1'b0) begin
      errors++;
      $display("FAIL expiry_pre: state=%0d hit=%b required 2 0", game_state, mole_hit);
    end
    step(1);
    e = exp_q.pop_front();
    checks++;
    if (game_state !== 3'd4 || mole_hit !== 1'b0 || hh_select !== 5'd0 || score !== e[15:8]) begin
      errors++;
      $display("FAIL expiry_hit: state=%0d hit=%b sel=%b score=%0d required 4 0 00000 %0d",
               game_state, mole_hit, hh_select, score, e[15:8]);
    end
  endtask

  task automatic test_mid_reset();
    logic [W-1:0] e;
    do_restart();
    step_to(5);
    keys = hh_select;
    exp_q.push_back({8'd1, 8'd0});
    step(2);
    keys = '0;
    step_to(10);
    e = exp_q.pop_front();
    checks++;
    if ({score, misses} !== e || mole_hit !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_hit: score=%0d miss=%0d hit=%b required %0d %0d 1",
               score, misses, mole_hit, e[15:8], e[7:0]);
    end
    step_to(12);
    rst = 1'b1;
    step(1);
    checks++;
    if (game_state !== 3'd1 || hh_select !== 5'd0 || mole_hit !== 1'b0 ||
        score !== 8'd0 || misses !== 8'd0 || time_left !== 7'd3) begin
      errors++;
      $display("FAIL mid_reset: state=%0d sel=%b hit=%b score=%0d miss=%0d time=%0d required 1 00000 0 0 0 3",
               game_state, hh_select, mole_hit, score, misses, time_left);
    end
    rst = 1'b0;
    step(5);
    checks++;
    if (game_state !== 3'd1 || hh_select !== 5'd0) begin
      errors++;
      $display("FAIL post_reset_idle: state=%0d sel=%b required 1 00000", game_state, hh_select);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_mole_changes();
    test_hit();
    test_misses();
    test_game_over();
    test_restart();
    test_expiry_hit();
    test_mid_reset();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
